// File: rtl/srt_div_pkg.sv
// Shared constants for the SRT divider arbiter.
// State encodings, latency and tag-width helpers.
package srt_div_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    function automatic int div_latency(input int dw);
        return dw / 2 + 3;
    endfunction

    function automatic int tag_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/srt_div_arbiter_rr.sv
// Combinational round-robin picker: first set request
// at or after the pointer, as one-hot grant and index.
module rr_arbiter
    import srt_div_pkg::*;
#(
    parameter int N = 4,
    parameter int W = tag_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] pointer,
    output logic [N-1:0] grant,
    output logic [W-1:0] index,
    output logic         found
);

    int pos;

    // scan from the pointer, wrapping, and keep the first hit
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        pos   = 0;
        for (int off = 0; off < N; off++) begin
            pos = (int'(pointer) + off) % N;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                index      = W'(pos);
            end
        end
    end

endmodule

// File: rtl/srt_div_arbiter.sv
// Shares one SRT radix-4 divider among NUM_REQ requesters.
// Option SRT_DIV_ARB_ZERO_BYPASS_EN: answer divide-by-zero locally.
module srt_div_arbiter
    import srt_div_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int DIV_LATENCY = div_latency(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_quotient,
    output logic [DATA_WIDTH-1:0]         resp_remainder,
    output logic                          resp_ov,
    output logic                          busy,
    output logic                          div_enable,
    output logic [DATA_WIDTH-1:0]         div_dividend,
    output logic [DATA_WIDTH-1:0]         div_divisor,
    input  logic [DATA_WIDTH-1:0]         div_quotient,
    input  logic [DATA_WIDTH-1:0]         div_remainder,
    input  logic                          div_ov
);

    localparam int TW = tag_width(NUM_REQ);
    localparam int CW = $clog2(DIV_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_LATENCY - 1);

    logic [2:0]            state;
    logic [TW-1:0]         ptr;
    logic [TW-1:0]         ptr_next;
    logic [TW-1:0]         tag;
    logic [TW-1:0]         gnt_idx;
    logic [NUM_REQ-1:0]    gnt;
    logic                  gnt_any;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] sel_dividend;
    logic [DATA_WIDTH-1:0] sel_divisor;

    rr_arbiter #(
        .N(NUM_REQ),
        .W(TW)
    ) u_rr (
        .req    (req_valid),
        .pointer(ptr),
        .grant  (gnt),
        .index  (gnt_idx),
        .found  (gnt_any)
    );

    assign sel_dividend = req_dividend[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_divisor  = req_divisor[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign ptr_next     = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

    assign busy       = (state != S_IDLE);
    assign div_enable = (state == S_ISSUE);
    assign req_ready  = (state == S_IDLE) ? gnt : '0;

    // response strobe goes only to the requester that owns the op
    always_comb begin
        resp_valid = '0;
        if (state == S_RESP) resp_valid[tag] = 1'b1;
    end

    // arbitration, issue, latency count and result capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            ptr            <= '0;
            tag            <= '0;
            cnt            <= '0;
            div_dividend   <= '0;
            div_divisor    <= '0;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_ov        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        tag          <= gnt_idx;
                        ptr          <= ptr_next;
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
`ifdef SRT_DIV_ARB_ZERO_BYPASS_EN
                        if (sel_divisor == '0) begin
                            resp_quotient  <= '1;
                            resp_remainder <= sel_dividend;
                            resp_ov        <= 1'b1;
                            state          <= S_RESP;
                        end else begin
                            state <= S_ISSUE;
                        end
`else
                        state <= S_ISSUE;
`endif
                    end
                end
                S_ISSUE: begin
                    cnt   <= CNT_LOAD;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) state <= S_CAPTURE;
                    else           cnt   <= cnt - 1'b1;
                end
                S_CAPTURE: begin
                    resp_quotient  <= div_quotient;
                    resp_remainder <= div_remainder;
                    resp_ov        <= div_ov;
                    state          <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srt_div_arbiter.sv
// Bench for srt_div_arbiter with a behavioural divider core stub.
// Vector table plus sequences for arbitration and reset corners.
module tb_srt_div_arbiter;
    import srt_div_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int DL = 7;
`ifdef SRT_DIV_ARB_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_dividend = '0;
    logic [NR*DW-1:0] req_divisor = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    resp_valid;
    logic [DW-1:0]    resp_quotient;
    logic [DW-1:0]    resp_remainder;
    logic             resp_ov;
    logic             busy;
    logic             div_enable;
    logic [DW-1:0]    div_dividend;
    logic [DW-1:0]    div_divisor;
    logic [DW-1:0]    div_quotient;
    logic [DW-1:0]    div_remainder;
    logic             div_ov;

    srt_div_arbiter #(
        .NUM_REQ(NR),
        .DATA_WIDTH(DW),
        .DIV_LATENCY(DL)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_quotient (resp_quotient),
        .resp_remainder(resp_remainder),
        .resp_ov       (resp_ov),
        .busy          (busy),
        .div_enable    (div_enable),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_ov        (div_ov)
    );

    always #5 clk = ~clk;

    // core stub: result appears DL cycles after the enable, junk before
    int            core_k;
    logic [DW-1:0] core_q;
    logic [DW-1:0] core_r;
    logic          core_ov;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_k  <= DL;
            core_q  <= '0;
            core_r  <= '0;
            core_ov <= 1'b0;
        end else if (div_enable) begin
            core_k  <= 1;
            core_ov <= (div_divisor == 0);
            core_q  <= (div_divisor == 0) ? 8'hFF : div_dividend / div_divisor;
            core_r  <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
        end else if (core_k < DL) begin
            core_k <= core_k + 1;
        end
    end

    assign div_quotient  = (core_k >= DL) ? core_q : 8'h5A;
    assign div_remainder = (core_k >= DL) ? core_r : 8'hA5;
    assign div_ov        = (core_k >= DL) ? core_ov : 1'b1;

    typedef struct {
        int            idx;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          ov;
        bit            zero;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int en_cnt = 0;
    int resp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(output int gi, output int gc);
        bit got = 1'b0;
        gi = -1;
        gc = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                got = 1'b1;
                gc  = cyc;
                for (int i = 0; i < NR; i++)
                    if (req_ready[i]) gi = i;
            end
        end
        if (!got) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(output logic [NR-1:0] rv, output logic [DW-1:0] q,
                             output logic [DW-1:0] r, output logic ov,
                             output int rc);
        bit got = 1'b0;
        rv = '0; q = '0; r = '0; ov = 1'b0; rc = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (resp_valid != '0) begin
                got = 1'b1;
                rv  = resp_valid;
                q   = resp_quotient;
                r   = resp_remainder;
                ov  = resp_ov;
                rc  = cyc;
            end
        end
        if (!got) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive(input int idx, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
        req_valid[idx] = 1'b1;
        req_dividend[idx*DW +: DW] = a;
        req_divisor[idx*DW +: DW]  = b;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        req_valid = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    vec_t vecs[8];

    initial begin : main
        int gi, gc, g1, g2, rc, e0, r0, prev_gc;
        logic [NR-1:0] rv;
        logic [DW-1:0] q, r;
        logic ov;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            begin : monitor
                logic [2:0]    ps = S_IDLE;
                logic [DW-1:0] pdd = '0;
                logic [DW-1:0] pdv = '0;
                forever begin
                    @(negedge clk);
                    if (div_enable) en_cnt++;
                    if (resp_valid != '0) resp_cnt++;
                    if (reset_n) begin
                        chk("onehot_ready", 32'($onehot0(req_ready)), 32'd1);
                        chk("onehot_resp", 32'($onehot0(resp_valid)), 32'd1);
                        if (div_enable)
                            chk("enable_state", 32'(dut.state), 32'(S_ISSUE));
                        if ((ps == S_ISSUE || ps == S_WAIT) &&
                            (dut.state == S_WAIT || dut.state == S_CAPTURE)) begin
                            chk("stable_dividend", 32'(div_dividend), 32'(pdd));
                            chk("stable_divisor", 32'(div_divisor), 32'(pdv));
                        end
                    end
                    ps  = dut.state;
                    pdd = div_dividend;
                    pdv = div_divisor;
                end
            end
        join_none

        vecs[0] = '{0, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0};
        vecs[1] = '{1, 8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 1'b0};
        vecs[2] = '{2, 8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 1'b0};
        vecs[3] = '{3, 8'd50,  8'd5,   8'd10,  8'd0,   1'b0, 1'b0};
        vecs[4] = '{1, 8'd0,   8'd9,   8'd0,   8'd0,   1'b0, 1'b0};
        vecs[5] = '{2, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0};
        vecs[6] = '{3, 8'd200, 8'd0,   8'hFF,  8'd200, 1'b1, 1'b1};
        vecs[7] = '{0, 8'd7,   8'd100, 8'd0,   8'd7,   1'b0, 1'b0};

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_enable", 32'(div_enable), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_q", 32'(resp_quotient), 32'd0);
        chk("rst_resp_ov", 32'(resp_ov), 32'd0);
        chk("rst_div_dividend", 32'(div_dividend), 32'd0);
        chk("rst_div_divisor", 32'(div_divisor), 32'd0);
        reset_n = 1'b1;

        // single requests from the vector table
        foreach (vecs[n]) begin
            @(posedge clk); #1;
            e0 = en_cnt;
            drive(vecs[n].idx, vecs[n].a, vecs[n].b);
            wait_grant(gi, gc);
            chk($sformatf("v%0d_grant_idx", n), 32'(gi), 32'(vecs[n].idx));
            @(posedge clk); #1;
            req_valid = '0;
            wait_resp(rv, q, r, ov, rc);
            chk($sformatf("v%0d_resp_valid", n), 32'(rv),
                32'(4'b0001 << vecs[n].idx));
            chk($sformatf("v%0d_latency", n), 32'(rc - gc),
                (vecs[n].zero && BYP) ? 32'd1 : 32'(DL + 3));
            chk($sformatf("v%0d_enables", n), 32'(en_cnt - e0),
                (vecs[n].zero && BYP) ? 32'd0 : 32'd1);
            chk($sformatf("v%0d_ov", n), 32'(ov), 32'(vecs[n].ov));
            if (!vecs[n].zero || BYP) begin
                chk($sformatf("v%0d_quotient", n), 32'(q), 32'(vecs[n].q));
                chk($sformatf("v%0d_remainder", n), 32'(r), 32'(vecs[n].r));
            end
            @(negedge clk);
            chk($sformatf("v%0d_strobe_len", n), 32'(resp_valid), 32'd0);
            chk($sformatf("v%0d_q_hold", n), 32'(resp_quotient), 32'(q));
        end

        // simultaneous req1/req2 with pointer at 0
        do_reset();
        @(posedge clk); #1;
        drive(1, 8'd255, 8'd16);
        drive(2, 8'd9, 8'd3);
        wait_grant(gi, g1);
        chk("pair_first", 32'(gi), 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_resp(rv, q, r, ov, rc);
        chk("pair1_rv", 32'(rv), 32'b0010);
        chk("pair1_q", 32'(q), 32'd15);
        chk("pair1_r", 32'(r), 32'd15);
        wait_grant(gi, g2);
        chk("pair_second", 32'(gi), 32'd2);
        chk("pair_gap", 32'(g2 - g1), 32'(DL + 4));
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(rv, q, r, ov, rc);
        chk("pair2_rv", 32'(rv), 32'b0100);
        chk("pair2_q", 32'(q), 32'd3);
        chk("pair2_r", 32'(r), 32'd0);

        // all four requesters valid for eight ops
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++)
            drive(i, 8'(i * 20 + 10), 8'(i + 2));
        e0 = en_cnt;
        prev_gc = 0;
        for (int n = 0; n < 8; n++) begin
            wait_grant(gi, gc);
            chk($sformatf("rr_order%0d", n), 32'(gi), 32'(n % NR));
            if (n > 0)
                chk($sformatf("rr_gap%0d", n), 32'(gc - prev_gc), 32'(DL + 4));
            prev_gc = gc;
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(rv, q, r, ov, rc);
        chk("rr_last_rv", 32'(rv), 32'b1000);
        chk("rr_last_q", 32'(q), 32'd14);
        chk("rr_enables", 32'(en_cnt - e0), 32'd8);

        // reset while waiting on the core
        @(posedge clk); #1;
        drive(0, 8'd77, 8'd3);
        wait_grant(gi, gc);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        r0 = resp_cnt;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_enable", 32'(div_enable), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_resp_q", 32'(resp_quotient), 32'd0);
        chk("mid_rst_resp_r", 32'(resp_remainder), 32'd0);
        chk("mid_rst_div_dividend", 32'(div_dividend), 32'd0);
        chk("mid_rst_div_divisor", 32'(div_divisor), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("mid_rst_no_resp", 32'(resp_cnt - r0), 32'd0);
        @(posedge clk); #1;
        drive(0, 8'd50, 8'd5);
        wait_grant(gi, gc);
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(rv, q, r, ov, rc);
        chk("post_rst_rv", 32'(rv), 32'b0001);
        chk("post_rst_q", 32'(q), 32'd10);
        chk("post_rst_r", 32'(r), 32'd0);
        chk("post_rst_ov", 32'(ov), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
